// File: rtl/fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arb
// Purpose  : Round-robin burst reader sharing one consumer between two FIFOs.
//            Optional word counters enabled by FIFO_RD_ARB_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_arb #(
    parameter int DATA_W    = 9,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              ch0_empty,
    input  logic              ch0_almost_full,
    input  logic [DATA_W-1:0] ch0_data,
    output logic              ch0_rd_en,
    input  logic              ch1_empty,
    input  logic              ch1_almost_full,
    input  logic [DATA_W-1:0] ch1_data,
    output logic              ch1_rd_en,
    input  logic              hold,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_ch,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic [15:0]       ch0_word_cnt,
    output logic [15:0]       ch1_word_cnt
);

    localparam int              CNT_W     = 8;
    localparam int              TMO_W     = 16;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic             valid_q, valid_d;
    logic             ch_q, ch_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic [1:0]       empty, af, req, rd_en;
    logic             grant_now;

    assign empty = {ch1_empty, ch0_empty};
    assign af    = {ch1_almost_full, ch0_almost_full};

    // Per-channel starvation timer; the owning channel's timer stays cleared.
    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic [TMO_W-1:0] tmo_q, tmo_d;
        logic             granted;

        assign granted = ((state_q != IDLE) && (gnt_q == 1'(i))) ||
                         (grant_now && (gnt_d == 1'(i)));

        always_comb begin
            tmo_d = tmo_q;
            if (empty[i] || granted) begin
                tmo_d = '0;
            end else if (tmo_q != TMO_MAX) begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_d;
            end
        end

        assign req[i] = !empty[i] && (af[i] || (tmo_q == TMO_MAX));
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        issue_cnt_d = issue_cnt_q;
        grant_now   = 1'b0;
        rd_en       = 2'b00;
        valid_d     = 1'b0;
        ch_d        = ch_q;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_now   = 1'b1;
                    gnt_d       = (req == 2'b11) ? ~last_q : req[1];
                    last_d      = gnt_d;
                    issue_cnt_d = '0;
                    state_d     = READ;
                end
            end
            READ: begin
                // While hold is high the empty flag is not acted upon.
                if (!hold) begin
                    if (!empty[gnt_q] && (issue_cnt_q < BURST_MAX)) begin
                        rd_en[gnt_q] = 1'b1;
                        valid_d      = 1'b1;
                        ch_d         = gnt_q;
                        sof_d        = (issue_cnt_q == '0);
                        eof_d        = (issue_cnt_q == BURST_MAX - 1'b1);
                        issue_cnt_d  = issue_cnt_q + 1'b1;
                        if (issue_cnt_d == BURST_MAX) begin
                            state_d = DRAIN;
                        end
                    end else if (empty[gnt_q]) begin
                        state_d = FLUSH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            issue_cnt_q <= '0;
            valid_q     <= 1'b0;
            ch_q        <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            issue_cnt_q <= issue_cnt_d;
            valid_q     <= valid_d;
            ch_q        <= ch_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
        end
    end

    // FIFO read data arrives one cycle after rd_en, aligned with valid_q.
    assign out_data  = valid_q ? (ch_q ? ch1_data : ch0_data) : '0;
    assign out_valid = valid_q;
    assign out_ch    = ch_q;
    assign out_sof   = sof_q;
    assign out_eof   = eof_q | (state_q == FLUSH);
    assign busy      = (state_q != IDLE);
    assign ch0_rd_en = rd_en[0];
    assign ch1_rd_en = rd_en[1];

`ifdef FIFO_RD_ARB_STAT_EN
    logic [1:0][15:0] word_cnt;

    for (genvar i = 0; i < 2; i++) begin : g_stat
        logic [15:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (valid_q && (ch_q == 1'(i)) && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign word_cnt[i] = cnt_q;
    end

    assign ch0_word_cnt = word_cnt[0];
    assign ch1_word_cnt = word_cnt[1];
`else
    assign ch0_word_cnt = '0;
    assign ch1_word_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/fifo_rd_arb.md
Name: fifo_rd_arb

Overview:
- Read-side scheduler in the sys_clk domain that shares one downstream consumer between two capture FIFOs (channel 0, channel 1). Both FIFOs are written from the capture clock domain.
- Watches each FIFO's empty and almost_full flags and picks a channel by round-robin.
- Drains the chosen FIFO in bursts of up to BURST_LEN words, then forwards the words tagged with channel, start-of-burst and end-of-burst markers.
- Replaces ad-hoc per-FIFO readers when more than one measurement channel is captured.

Parameters:
- DATA_W, 9, width of FIFO read data and out_data.
- BURST_LEN, 16, maximum words per burst; legal range 2..255.
- TIMEOUT, 1024, sys_clk cycles a non-empty, non-almost_full channel waits before it may request a partial burst; legal range 2..65535.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch0_empty  in  1  FIFO 0 empty flag.
- ch0_almost_full  in  1  FIFO 0 almost_full flag.
- ch0_data  in  DATA_W  FIFO 0 read data; valid 1 cycle after ch0_rd_en.
- ch0_rd_en  out  1  FIFO 0 read strobe.
- ch1_empty, ch1_almost_full, ch1_data, ch1_rd_en: same as channel 0, for FIFO 1.
- hold  in  1  downstream pause; blocks new reads.
- out_data  out  DATA_W  forwarded word.
- out_valid  out  1  out_data valid, one-cycle pulse per word.
- out_ch  out  1  channel of out_data.
- out_sof  out  1  first word of burst, coincident with out_valid.
- out_eof  out  1  burst end.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface (already decided): one clock, sys_clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - All outputs 0; rd_en deasserts combinationally-immediately on reset.
  - FSM = IDLE, round-robin pointer last = 1 (so channel 0 wins the first tie).
  - Timeout counters = 0.
  - Reset mid-burst abandons the burst; no out_eof is emitted.
- Request: req_i = !chi_empty && (chi_almost_full || tmo_i == TIMEOUT-1).
- Timeout counters tmo_i:
  - Increment while chi_empty=0 and channel i is not granted; saturate at TIMEOUT-1.
  - Clear when chi_empty=1 or when channel i is granted.
- FSM IDLE:
  - Neither request: stay.
  - One request: grant it.
  - Both request: grant the channel != last.
  - On grant: latch gnt, set last = gnt, issue_cnt = 0, go READ.
- FSM READ: issue condition is hold=0 && ch[gnt]_empty=0 && issue_cnt < BURST_LEN.
  - When issued: rd_en[gnt]=1 (combinational from state and inputs), issue_cnt++.
  - rd_en is never asserted on an empty FIFO or on the non-granted channel.
  - issue_cnt reaches BURST_LEN → go DRAIN.
  - hold=0 && ch[gnt]_empty=1 → go FLUSH.
  - hold=1: stay in READ; the empty check is suspended.
- FSM DRAIN: one cycle, during which the last word returns; then IDLE.
- FSM FLUSH: one cycle; assert out_eof=1 with out_valid=0; then IDLE.
- Output pipeline (registered, latency 1 from rd_en):
  - out_valid = rd_en delayed 1 cycle.
  - out_data = ch[gnt]_data.
  - out_ch = gnt.
  - out_sof = 1 on the word issued at issue_cnt==0.
  - out_eof = 1 on the word issued at issue_cnt==BURST_LEN-1.
- Each burst ends in exactly one out_eof: either on the last word, or as a standalone FLUSH pulse one cycle after the last word's out_valid.
- Back-to-back bursts: at least one IDLE cycle between bursts.
- A channel going almost_full during another channel's burst waits; no preemption.
- Pointer wraps 0→1→0; with both channels requesting continuously, grants alternate strictly.

Optional Feature:
- Macro FIFO_RD_ARB_STAT_EN.
- Defined:
  - Adds output ports ch0_word_cnt and ch1_word_cnt, 16 bits each.
  - Each counts words forwarded for its channel (out_valid && out_ch==i).
  - Counters saturate at 0xFFFF and reset to 0.
- Undefined:
  - Ports still exist, tied to 0.
  - No counter logic is synthesized; all other behaviour is identical.

Test Plan:
- Reset, then ch0_almost_full=1, ch0_empty=0 for 40 cycles → 16 consecutive ch0_rd_en. out_valid trails each rd_en by 1 cycle with out_ch=0, out_sof on word 1, out_eof on word 16; busy falls after DRAIN.
- Both almost_full held high for 4 bursts → grant order 0,1,0,1; each burst 16 words; ≥1 idle cycle between bursts.
- ch1 holds 5 words, almost_full=0 → no read until 1023 non-empty cycles have elapsed; then 5 reads and empty → FLUSH. out_eof=1 with out_valid=0 one cycle after the 5th word.
- hold=1 asserted for 10 cycles mid-burst after 6 words → no rd_en during hold; burst resumes and totals 16 words; data order is preserved.
- rst_n asserted low mid-burst → rd_en, out_valid and busy go 0 immediately; after release the next burst grants channel 0 on a tie.
- With FIFO_RD_ARB_STAT_EN, 3 full ch0 bursts → ch0_word_cnt=48, ch1_word_cnt=0; without the macro both read 0.
